dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter for the single-port data memory (`dmem`). Port 0 is the CPU execute-stage load/store path. Port 1 is a secondary bus master (UART bootloader DMA / debug loader) with a valid/ready request channel and a response strobe. The CPU has priority. A starvation counter forces a one-cycle DMA grant, stalling the CPU, after `MAX_WAIT` denied cycles. The block sits between `cpu` and `dmem` and owns the routing of dmem's one-cycle read data back to whichever requester issued the read.

## Interface
- `MAX_WAIT`, 8, consecutive denied DMA cycles before a forced grant (legal range 1..255).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cpu_en`  in  1  CPU access request this cycle.
- `cpu_we`  in  4  CPU byte write enables; 0 means read.
- `cpu_addr`  in  14  CPU word address.
- `cpu_din`  in  32  CPU write data.
- `cpu_dout`  out  32  read data for the CPU read granted in the previous cycle.
- `cpu_stall`  out  1  CPU access not performed this cycle; the core must re-present it next cycle.
- `dma_req_valid`  in  1  DMA request pending.
- `dma_req_ready`  out  1  DMA request granted this cycle.
- `dma_we`  in  4  DMA byte write enables; 0 means read.
- `dma_addr`  in  14  DMA word address.
- `dma_din`  in  32  DMA write data.
- `dma_rsp_valid`  out  1  DMA read data valid.
- `dma_rsp_data`  out  32  DMA read data.
- `mem_en`  out  1  to `dmem.en`.
- `mem_we`  out  4  to `dmem.we`.
- `mem_addr`  out  14  to `dmem.addr`.
- `mem_din`  out  32  to `dmem.din`.
- `mem_dout`  in  32  from `dmem.dout`.

## Operation
- **States:** `ARB_NORMAL` and `ARB_FORCE`. `ARB_FORCE` lasts exactly one cycle, then the FSM returns to `ARB_NORMAL`.
- **Grant decision (combinational, per cycle):**
  - `ARB_FORCE` and `dma_req_valid`: DMA is granted, and `cpu_stall = cpu_en`.
  - Otherwise, `cpu_en`: CPU is granted, and `dma_req_ready = 0`.
  - Otherwise, `dma_req_valid`: DMA is granted, with no stall.
  - Otherwise: `mem_en = 0`.
- **Memory port muxing:** `mem_*` is driven from the granted port. When nothing is granted, `mem_we = 0`, and `mem_addr` / `mem_din` are 0.
- **DMA handshake:** DMA uses valid/ready. The master holds `dma_req_valid` and its payload stable until `dma_req_ready`. The transfer occurs on the cycle where both are high.
- **Wait counter:**
  - Increments each cycle that `dma_req_valid && !dma_req_ready`, saturating at `MAX_WAIT`.
  - Clears on any DMA grant, and whenever `dma_req_valid` is low.
  - When a denied cycle brings the count to `MAX_WAIT`, the next state is `ARB_FORCE`.
- **Dropped request in `ARB_FORCE`:** if `dma_req_valid` has dropped, the cycle behaves as `ARB_NORMAL`, with no stall.
- **Read tag:** a registered tag records the owner of a granted read (`mem_en && mem_we == 0`).
  - Next cycle, `dma_rsp_valid = 1` if the owner was DMA.
  - `dma_rsp_data = mem_dout` when `dma_rsp_valid = 1`, else 0.
  - `cpu_dout = mem_dout` always, so CPU timing is unchanged from direct connection.
- **DMA writes** produce no response.

## Timing
- **Outputs on reset:** while `rst` is high, `mem_en = 0`, `mem_we = 0`, `dma_req_ready = 0`, `cpu_stall = 0` and `dma_rsp_valid = 0`.
- **Registers on reset:** on the first clock edge with `rst` high, the FSM goes to `ARB_NORMAL`, the counter to 0 and the tag to none.
- **Latency:**
  - Grant is zero-cycle (same cycle as request).
  - Read data appears exactly 1 cycle after grant.
  - Worst-case DMA wait is `MAX_WAIT + 1` cycles under continuous CPU traffic.
- **Simultaneous events:**
  - CPU and DMA both requesting in `ARB_NORMAL`: CPU wins.
  - Forced grant: exactly one CPU stall cycle per `MAX_WAIT` denials.
- **Back-to-back:** DMA requests may be granted on consecutive cycles. `dma_rsp_valid` may be high on consecutive cycles.
- **Reset mid-operation:** an in-flight read response is discarded, and `dma_rsp_valid` is 0 in the cycle after the reset edge.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum `ARB_NORMAL` / `ARB_FORCE`.
  - owner enum `OWN_NONE` / `OWN_CPU` / `OWN_DMA`.
  - dmem widths (`DMEM_AW = 14`, `DMEM_DW = 32`).
- Optional sub-module `starve_counter`: saturating counter with `inc`, `clr` and a `hit` output at `MAX_WAIT`. All remaining logic lives in the top module.

## Test plan
- **CPU only:** `cpu_en = 1` read at addr `0x0010`, with dmem preloaded `0xDEADBEEF` -> `mem_en = 1`, no stall; `cpu_dout = 0xDEADBEEF` next cycle; `dma_rsp_valid` stays 0.
- **DMA only:** DMA write `we = 0xF` addr `0x0020` data `0x12345678`, then DMA read of the same address -> `ready` on both same-cycle; `dma_rsp_valid = 1` with `0x12345678` one cycle after the read grant.
- **Starvation:** `MAX_WAIT = 4`, CPU requesting every cycle, DMA read pending -> `ready = 0` for 4 cycles; the 5th cycle has `ready = 1` and `cpu_stall = 1`; the 6th cycle has the CPU granted again.
- **Forced-cycle drop:** DMA drops valid in the `ARB_FORCE` cycle -> no stall, CPU granted, counter 0.
- **Reset mid-read:** DMA read granted, then `rst` on the next edge -> `dma_rsp_valid = 0`, all grant outputs 0 while `rst` is high, counter and state cleared.
- **Back-to-back:** alternating idle CPU cycles with 3 queued DMA reads -> 3 consecutive `dma_rsp_valid` pulses with correct data, in order.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the dmem arbiter
// Purpose: arbiter state enum, read-owner enum and dmem port widths.
// Ports: none (package).
package mem_arb_pkg;

  localparam int DMEM_AW = 14;
  localparam int DMEM_DW = 32;
  localparam int DMEM_WE = DMEM_DW / 8;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

endpackage

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating count of consecutive denied DMA cycles
// Purpose: counts denied DMA cycles up to MAX_WAIT and flags when the next
//          denial would reach MAX_WAIT.
// Ports:
//   i_clk  - clock
//   i_rst  - synchronous active-high reset
//   i_inc  - DMA request denied this cycle
//   i_clr  - DMA granted or not requesting this cycle
//   o_hit  - count is one short of MAX_WAIT (a denial now reaches MAX_WAIT)
module starve_counter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);

  localparam logic [7:0] LP_MAX = 8'(MAX_WAIT);

  logic [7:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= 8'd0;
    end else if (i_inc && (r_count != LP_MAX)) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Depends only on the registered count so the arbiter can combine it with
  // its own same-cycle denial without a combinational loop.
  assign o_hit = (r_count >= (LP_MAX - 8'd1));

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter for the single-port data memory
// Purpose: CPU-priority arbitration with a starvation-forced DMA grant and
//          routing of one-cycle read data back to the issuing requester.
// Ports:
//   i_clk, i_rst                      - clock, synchronous active-high reset
//   i_cpu_en/we/addr/din              - CPU access request
//   o_cpu_dout                        - CPU read data (dmem data, passthrough)
//   o_cpu_stall                       - CPU access not performed this cycle
//   i_dma_req_valid / o_dma_req_ready - DMA request handshake
//   i_dma_we/addr/din                 - DMA request payload
//   o_dma_rsp_valid / o_dma_rsp_data  - DMA read response
//   o_mem_en/we/addr/din, i_mem_dout  - dmem port
module dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cpu_en,
  input  logic [DMEM_WE-1:0] i_cpu_we,
  input  logic [DMEM_AW-1:0] i_cpu_addr,
  input  logic [DMEM_DW-1:0] i_cpu_din,
  output logic [DMEM_DW-1:0] o_cpu_dout,
  output logic               o_cpu_stall,
  input  logic               i_dma_req_valid,
  output logic               o_dma_req_ready,
  input  logic [DMEM_WE-1:0] i_dma_we,
  input  logic [DMEM_AW-1:0] i_dma_addr,
  input  logic [DMEM_DW-1:0] i_dma_din,
  output logic               o_dma_rsp_valid,
  output logic [DMEM_DW-1:0] o_dma_rsp_data,
  output logic               o_mem_en,
  output logic [DMEM_WE-1:0] o_mem_we,
  output logic [DMEM_AW-1:0] o_mem_addr,
  output logic [DMEM_DW-1:0] o_mem_din,
  input  logic [DMEM_DW-1:0] i_mem_dout
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  owner_t     r_tag;
  logic       w_grant_cpu;
  logic       w_grant_dma;
  logic       w_inc;
  logic       w_clr;
  logic       w_hit;

  starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_inc),
    .i_clr (w_clr),
    .o_hit (w_hit)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ARB_NORMAL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_grant_cpu  = 1'b0;
    w_grant_dma  = 1'b0;
    w_state_next = ARB_NORMAL;
    if (!i_rst) begin
      // A forced cycle whose DMA request has vanished falls through to the
      // normal priority order, so the CPU is not stalled for nothing.
      if ((r_state == ARB_FORCE) && i_dma_req_valid) begin
        w_grant_dma = 1'b1;
      end else if (i_cpu_en) begin
        w_grant_cpu = 1'b1;
      end else if (i_dma_req_valid) begin
        w_grant_dma = 1'b1;
      end
    end
    w_inc = i_dma_req_valid && !w_grant_dma;
    w_clr = !i_dma_req_valid || w_grant_dma;
    // The denial that brings the count to MAX_WAIT schedules the forced grant.
    if (w_inc && w_hit) begin
      w_state_next = ARB_FORCE;
    end
  end

  assign o_dma_req_ready = w_grant_dma;
  assign o_cpu_stall     = !i_rst && i_cpu_en && !w_grant_cpu;

  always_comb begin
    o_mem_en   = 1'b0;
    o_mem_we   = '0;
    o_mem_addr = '0;
    o_mem_din  = '0;
    if (w_grant_dma) begin
      o_mem_en   = 1'b1;
      o_mem_we   = i_dma_we;
      o_mem_addr = i_dma_addr;
      o_mem_din  = i_dma_din;
    end else if (w_grant_cpu) begin
      o_mem_en   = 1'b1;
      o_mem_we   = i_cpu_we;
      o_mem_addr = i_cpu_addr;
      o_mem_din  = i_cpu_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag <= OWN_NONE;
    end else if (o_mem_en && (o_mem_we == '0)) begin
      r_tag <= w_grant_dma ? OWN_DMA : OWN_CPU;
    end else begin
      r_tag <= OWN_NONE;
    end
  end

  // Gated by reset so a response in flight at the reset edge never surfaces.
  assign o_dma_rsp_valid = !i_rst && (r_tag == OWN_DMA);
  assign o_dma_rsp_data  = o_dma_rsp_valid ? i_mem_dout : '0;
  assign o_cpu_dout      = i_mem_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_en = 1'b0;
  logic [3:0]  cpu_we = '0;
  logic [13:0] cpu_addr = '0;
  logic [31:0] cpu_din = '0;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic        dma_req_valid = 1'b0;
  logic        dma_req_ready;
  logic [3:0]  dma_we = '0;
  logic [13:0] dma_addr = '0;
  logic [31:0] dma_din = '0;
  logic        dma_rsp_valid;
  logic [31:0] dma_rsp_data;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(4)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_cpu_en        (cpu_en),
    .i_cpu_we        (cpu_we),
    .i_cpu_addr      (cpu_addr),
    .i_cpu_din       (cpu_din),
    .o_cpu_dout      (cpu_dout),
    .o_cpu_stall     (cpu_stall),
    .i_dma_req_valid (dma_req_valid),
    .o_dma_req_ready (dma_req_ready),
    .i_dma_we        (dma_we),
    .i_dma_addr      (dma_addr),
    .i_dma_din       (dma_din),
    .o_dma_rsp_valid (dma_rsp_valid),
    .o_dma_rsp_data  (dma_rsp_data),
    .o_mem_en        (mem_en),
    .o_mem_we        (mem_we),
    .o_mem_addr      (mem_addr),
    .o_mem_din       (mem_din),
    .i_mem_dout      (mem_dout)
  );

  logic [31:0] dmem [0:16383];

  initial begin
    dmem[14'h0010] = 32'hDEADBEEF;
    dmem[14'h0030] = 32'hA5A50030;
    dmem[14'h0040] = 32'h40404040;
    dmem[14'h0041] = 32'h41414141;
    dmem[14'h0042] = 32'h42424242;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) dmem[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
      end
      if (mem_we == 4'h0) mem_dout <= dmem[mem_addr];
    end
  end

  typedef struct {
    bit          ready;
    bit          stall;
    bit          en;
    logic [3:0]  we;
    logic [13:0] addr;
    logic [31:0] din;
    bit          rsp_v;
    bit          chk_cpu;
    logic [31:0] cpu_d;
  } exp_t;

  exp_t        rec_q[$];
  logic [31:0] rsp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  bit          prev_dma_rd = 1'b0;
  bit          prev_cpu_rd = 1'b0;
  logic [31:0] prev_rd = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Drives one cycle of inputs and queues the hand-computed expectations.
  // e_rd is the data the read granted in this cycle must return next cycle.
  task automatic step(input bit r,
                      input bit ce, input logic [3:0] cwe, input logic [13:0] ca, input logic [31:0] cd,
                      input bit dv, input logic [3:0] dwe, input logic [13:0] da, input logic [31:0] dd,
                      input bit e_rdy, input bit e_stl, input logic [31:0] e_rd);
    exp_t e;
    bit   cpu_g;
    rst = r;
    cpu_en = ce; cpu_we = cwe; cpu_addr = ca; cpu_din = cd;
    dma_req_valid = dv; dma_we = dwe; dma_addr = da; dma_din = dd;
    cpu_g = !r && ce && !e_rdy;
    e.ready = e_rdy;
    e.stall = e_stl;
    e.en    = e_rdy || cpu_g;
    e.we    = e_rdy ? dwe : (cpu_g ? cwe : 4'h0);
    e.addr  = e_rdy ? da  : (cpu_g ? ca  : 14'h0);
    e.din   = e_rdy ? dd  : (cpu_g ? cd  : 32'h0);
    e.rsp_v = prev_dma_rd && !r;
    if (e.rsp_v) rsp_q.push_back(prev_rd);
    e.chk_cpu = prev_cpu_rd && !r;
    e.cpu_d   = prev_rd;
    prev_dma_rd = e_rdy && (dwe == 4'h0);
    prev_cpu_rd = cpu_g && (cwe == 4'h0);
    prev_rd     = e_rd;
    rec_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  exp_t m;

  initial begin
    forever begin
      @(negedge clk);
      if (rec_q.size() > 0) begin
        m = rec_q.pop_front();
        chk("dma_req_ready", 32'(dma_req_ready), 32'(m.ready));
        chk("cpu_stall", 32'(cpu_stall), 32'(m.stall));
        chk("mem_en", 32'(mem_en), 32'(m.en));
        chk("mem_we", 32'(mem_we), 32'(m.we));
        chk("mem_addr", 32'(mem_addr), 32'(m.addr));
        chk("mem_din", mem_din, m.din);
        chk("dma_rsp_valid", 32'(dma_rsp_valid), 32'(m.rsp_v));
        if (m.chk_cpu) chk("cpu_dout", cpu_dout, m.cpu_d);
        if (dma_rsp_valid === 1'b1) begin
          if (rsp_q.size() > 0) begin
            chk("dma_rsp_data", dma_rsp_data, rsp_q.pop_front());
          end else begin
            n_checks++;
            n_fail++;
            $display("FAIL dma_rsp_unexpected: got data %h expected no response", dma_rsp_data);
          end
        end else begin
          chk("dma_rsp_data_idle", dma_rsp_data, 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    // reset: all grant outputs low even with both requesters active
    step(1, 1, 4'h0, 14'h10, 0, 1, 4'h0, 14'h30, 0, 0, 0, 0);
    step(1, 0, 4'h0, 14'h00, 0, 0, 4'h0, 14'h00, 0, 0, 0, 0);
    // CPU only read
    step(0, 1, 4'h0, 14'h10, 0, 0, 4'h0, 14'h00, 0, 0, 0, 32'hDEADBEEF);
    step(0, 0, 4'h0, 14'h00, 0, 0, 4'h0, 14'h00, 0, 0, 0, 0);
    // DMA only write then read back
    step(0, 0, 4'h0, 14'h00, 0, 1, 4'hF, 14'h20, 32'h12345678, 1, 0, 0);
    step(0, 0, 4'h0, 14'h00, 0, 1, 4'h0, 14'h20, 0, 1, 0, 32'h12345678);
    step(0, 0, 4'h0, 14'h00, 0, 0, 4'h0, 14'h00, 0, 0, 0, 0);
    // starvation: 4 denials, forced grant with stall, CPU back next cycle
    repeat (4) step(0, 1, 4'h0, 14'h10, 0, 1, 4'h0, 14'h30, 0, 0, 0, 32'hDEADBEEF);
    step(0, 1, 4'h0, 14'h10, 0, 1, 4'h0, 14'h30, 0, 1, 1, 32'hA5A50030);
    step(0, 1, 4'h0, 14'h10, 0, 0, 4'h0, 14'h00, 0, 0, 0, 32'hDEADBEEF);
    // DMA drops valid in the forced cycle: no stall, CPU granted
    repeat (4) step(0, 1, 4'h0, 14'h10, 0, 1, 4'h0, 14'h30, 0, 0, 0, 32'hDEADBEEF);
    step(0, 1, 4'hF, 14'h100, 32'hCAFE0001, 0, 4'h0, 14'h00, 0, 0, 0, 0);
    // counter restarted from 0: a full 4 denials again before forcing
    repeat (4) step(0, 1, 4'h0, 14'h10, 0, 1, 4'h0, 14'h30, 0, 0, 0, 32'hDEADBEEF);
    step(0, 1, 4'h0, 14'h10, 0, 1, 4'h0, 14'h30, 0, 1, 1, 32'hA5A50030);
    step(0, 0, 4'h0, 14'h00, 0, 0, 4'h0, 14'h00, 0, 0, 0, 0);
    // reset mid-read: response discarded, outputs low during reset
    step(0, 0, 4'h0, 14'h00, 0, 1, 4'h0, 14'h20, 0, 1, 0, 32'h12345678);
    step(1, 1, 4'h0, 14'h10, 0, 1, 4'h0, 14'h20, 0, 0, 0, 0);
    step(1, 1, 4'h0, 14'h10, 0, 1, 4'h0, 14'h20, 0, 0, 0, 0);
    // state and counter cleared: full 4 denials before the forced grant
    repeat (4) step(0, 1, 4'h0, 14'h10, 0, 1, 4'h0, 14'h20, 0, 0, 0, 32'hDEADBEEF);
    step(0, 1, 4'h0, 14'h10, 0, 1, 4'h0, 14'h20, 0, 1, 1, 32'h12345678);
    step(0, 0, 4'h0, 14'h00, 0, 0, 4'h0, 14'h00, 0, 0, 0, 0);
    // back-to-back DMA reads with the CPU idle
    step(0, 0, 4'h0, 14'h00, 0, 1, 4'h0, 14'h40, 0, 1, 0, 32'h40404040);
    step(0, 0, 4'h0, 14'h00, 0, 1, 4'h0, 14'h41, 0, 1, 0, 32'h41414141);
    step(0, 0, 4'h0, 14'h00, 0, 1, 4'h0, 14'h42, 0, 1, 0, 32'h42424242);
    step(0, 0, 4'h0, 14'h00, 0, 0, 4'h0, 14'h00, 0, 0, 0, 0);
    step(0, 0, 4'h0, 14'h00, 0, 0, 4'h0, 14'h00, 0, 0, 0, 0);
    step(0, 0, 4'h0, 14'h00, 0, 0, 4'h0, 14'h00, 0, 0, 0, 0);
    for (int i = 0; i < 10 && rec_q.size() > 0; i++) @(posedge clk);
    chk("records_drained", 32'(rec_q.size()), 32'h0);
    chk("responses_drained", 32'(rsp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
